// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - time-setting edit FSM with wrap-around fields, blink and idle timeout
module time_set_ctrl #(
    parameter logic [25:0] BLINK_MAX    = 26'd24_999_999,
    parameter logic [7:0]  TIMEOUT_HALF = 8'd20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic [7:0] s_dec,
    input  logic [7:0] m_dec,
    input  logic [7:0] h_dec,
    output logic [7:0] set_s,
    output logic [7:0] set_m,
    output logic [7:0] set_h,
    output logic       load,
    output logic [1:0] edit_sel,
    output logic       blink,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_H = 2'd1,
        EDIT_M = 2'd2,
        EDIT_S = 2'd3
    } state_t;

    localparam logic [7:0] MAX_H  = 8'd23;
    localparam logic [7:0] MAX_MS = 8'd59;

    state_t      state;
    state_t      state_nx;
    logic [25:0] blink_cnt;
    logic [7:0]  to_cnt;
    logic        any_key;
    logic        half_done;
    logic        timeout;
    logic        commit;
    logic        step_up;
    logic        step_dn;

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] wrap_dec(input logic [7:0] v, input logic [7:0] max);
        return (v == 8'd0 || v > max) ? max : v - 8'd1;
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] max);
        return (v > max) ? 8'd0 : v;
    endfunction

    assign any_key   = key_mode | key_inc | key_dec;
    assign half_done = (state != IDLE) && (blink_cnt == BLINK_MAX);
    // A key on the same edge as the last half-period keeps the edit alive.
    assign timeout   = half_done && !any_key && (to_cnt >= TIMEOUT_HALF - 8'd1);

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        case (state)
            IDLE: begin
                if (key_mode) state_nx = EDIT_H;
            end
            EDIT_H, EDIT_M, EDIT_S: begin
                if (timeout) begin
                    state_nx = IDLE;
                end else if (key_mode) begin
                    case (state)
                        EDIT_H:  state_nx = EDIT_M;
                        EDIT_M:  state_nx = EDIT_S;
                        default: begin
                            state_nx = IDLE;
                            commit   = 1'b1;
                        end
                    endcase
                end else begin
                    step_up = key_inc & ~key_dec;
                    step_dn = key_dec & ~key_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            edit_sel <= 2'd0;
            busy     <= 1'b0;
            load     <= 1'b0;
        end else begin
            state    <= state_nx;
            edit_sel <= state_nx;
            busy     <= (state_nx != IDLE);
            load     <= commit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= 26'd0;
            blink     <= 1'b0;
            to_cnt    <= 8'd0;
        end else if (state == IDLE || state_nx == IDLE) begin
            blink_cnt <= 26'd0;
            blink     <= 1'b0;
            to_cnt    <= 8'd0;
        end else begin
            if (half_done) begin
                blink_cnt <= 26'd0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 26'd1;
            end
            if (any_key)        to_cnt <= 8'd0;
            else if (half_done) to_cnt <= to_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_h <= 8'd0;
            set_m <= 8'd0;
            set_s <= 8'd0;
        end else if (state == IDLE) begin
            if (key_mode) begin
                set_h <= clamp(h_dec, MAX_H);
                set_m <= clamp(m_dec, MAX_MS);
                set_s <= clamp(s_dec, MAX_MS);
            end
        end else if (step_up) begin
            case (state)
                EDIT_H:  set_h <= wrap_inc(set_h, MAX_H);
                EDIT_M:  set_m <= wrap_inc(set_m, MAX_MS);
                default: set_s <= wrap_inc(set_s, MAX_MS);
            endcase
        end else if (step_dn) begin
            case (state)
                EDIT_H:  set_h <= wrap_dec(set_h, MAX_H);
                EDIT_M:  set_m <= wrap_dec(set_m, MAX_MS);
                default: set_s <= wrap_dec(set_s, MAX_MS);
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode, key_inc, key_dec;
    logic [7:0] s_dec, m_dec, h_dec;
    logic [7:0] set_s, set_m, set_h;
    logic       load, blink, busy;
    logic [1:0] edit_sel;

    int n_cmp  = 0;
    int n_bad  = 0;
    int load_hits = 0;
    int snap;

    time_set_ctrl #(.BLINK_MAX(26'd4), .TIMEOUT_HALF(8'd6)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
        .s_dec(s_dec), .m_dec(m_dec), .h_dec(h_dec),
        .set_s(set_s), .set_m(set_m), .set_h(set_h),
        .load(load), .edit_sel(edit_sel), .blink(blink), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load) load_hits++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        key_mode = m; key_inc = i; key_dec = d;
        @(posedge clk); #1;
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n = 1'b0; key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        h_dec = 8'd12; m_dec = 8'd34; s_dec = 8'd56;
        idle_cycles(3);
        rst_n = 1'b1;
        snap = load_hits;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (busy || edit_sel != 2'd0) chk("rst_idle", {30'd0, edit_sel}, 32'd0);
        end
        chk("rst_load_seen", load_hits - snap, 0);
        chk("rst_set_h", set_h, 0);
        chk("rst_set_m", set_m, 0);
        chk("rst_set_s", set_s, 0);
        chk("rst_edit_sel", edit_sel, 0);
        chk("rst_blink", blink, 0);
        chk("rst_busy", busy, 0);

        // Entry and hour wrap
        press(1, 0, 0);
        h_dec = 8'd5;
        chk("entry_sel", edit_sel, 1);
        chk("entry_busy", busy, 1);
        chk("entry_h", set_h, 12);
        chk("entry_m", set_m, 34);
        chk("entry_s", set_s, 56);
        chk("entry_blink", blink, 0);
        repeat (12) press(0, 1, 0);
        chk("h_inc_wrap", set_h, 0);
        press(0, 0, 1);
        chk("h_dec_wrap", set_h, 23);

        // Full commit
        press(1, 0, 0);
        chk("sel_m", edit_sel, 2);
        repeat (26) press(0, 1, 0);
        chk("m_inc_wrap", set_m, 0);
        press(1, 0, 0);
        chk("sel_s", edit_sel, 3);
        press(0, 0, 1);
        chk("s_dec", set_s, 55);
        press(1, 0, 0);
        chk("commit_load", load, 1);
        chk("commit_busy", busy, 0);
        chk("commit_sel", edit_sel, 0);
        chk("commit_h", set_h, 23);
        chk("commit_m", set_m, 0);
        chk("commit_s", set_s, 55);
        idle_cycles(1);
        chk("load_one_cycle", load, 0);
        chk("hold_h", set_h, 23);
        chk("hold_s", set_s, 55);

        // Timeout with no keys
        snap = load_hits;
        press(1, 0, 0);
        for (int k = 1; k < 30; k++) begin
            idle_cycles(1);
            chk($sformatf("blink_k%0d", k), blink, (k / 5) % 2);
            if (k == 29) chk("to_still_busy", edit_sel, 1);
        end
        idle_cycles(1);
        chk("to_exit_sel", edit_sel, 0);
        chk("to_exit_busy", busy, 0);
        chk("to_exit_blink", blink, 0);
        chk("to_no_load", load_hits - snap, 0);
        chk("to_hold_h", set_h, 5);

        // Timeout extended by a key at cycle 20
        press(1, 0, 0);
        idle_cycles(19);
        press(0, 1, 0);
        chk("ext_h_inc", set_h, 6);
        idle_cycles(29);
        chk("ext_busy_49", busy, 1);
        chk("ext_blink_49", blink, 1);
        idle_cycles(1);
        chk("ext_exit_50", busy, 0);
        chk("ext_no_load", load_hits - snap, 0);

        // Conflicting keys
        press(1, 0, 0);
        chk("cf_entry_h", set_h, 5);
        press(1, 0, 0);
        press(0, 1, 1);
        chk("cf_incdec_m", set_m, 34);
        chk("cf_incdec_sel", edit_sel, 2);
        press(1, 1, 0);
        chk("cf_mode_sel", edit_sel, 3);
        chk("cf_mode_m", set_m, 34);
        press(1, 0, 0);
        chk("cf_commit", load, 1);

        // Clamp on entry, then reset mid-edit
        h_dec = 8'd30; m_dec = 8'd60;
        press(1, 0, 0);
        chk("clamp_h", set_h, 0);
        chk("clamp_m", set_m, 0);
        chk("clamp_s", set_s, 56);
        press(1, 0, 0);
        press(1, 0, 0);
        chk("mid_sel_s", edit_sel, 3);
        snap = load_hits;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", edit_sel, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s", set_s, 0);
        chk("arst_load", load, 0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(5);
        chk("arst_no_load", load_hits - snap, 0);
        chk("arst_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-setting controller for the `clk_gen` seconds/minutes/hours counter. Debounced key pulses drive an edit state machine. The block snapshots the running time, lets the user step hours, minutes and seconds up or down with wrap-around, and then issues a one-cycle load strobe with the edited values. It also produces a field-select code and a half-period blink for the display driver, and aborts an idle edit after a configurable timeout.

## Interface
Parameters:
- BLINK_MAX, 26'd24_999_999, blink half-period minus 1, in clk cycles (0.5 s at 50 MHz)
- TIMEOUT_HALF, 8'd20, number of blink half-periods without a key before an edit is aborted (10 s)

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- key_mode  in  1  single-cycle pulse: enter edit / advance field / commit
- key_inc  in  1  single-cycle pulse: increment the selected field
- key_dec  in  1  single-cycle pulse: decrement the selected field
- s_dec  in  8  current seconds, binary 0..59
- m_dec  in  8  current minutes, binary 0..59
- h_dec  in  8  current hours, binary 0..23
- set_s  out  8  edited seconds
- set_m  out  8  edited minutes
- set_h  out  8  edited hours
- load  out  1  one-cycle strobe; the counter takes set_h/m/s
- edit_sel  out  2  0 none, 1 hours, 2 minutes, 3 seconds
- blink  out  1  toggles every BLINK_MAX+1 cycles while editing; 0 in IDLE
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EDIT_H, EDIT_M, EDIT_S. edit_sel = 0/1/2/3 respectively.
- **IDLE**, on key_mode: capture h_dec/m_dec/s_dec into set_h/m/s.
  - An out-of-range capture (h>23, m or s>59) loads 0 for that field.
  - Go to EDIT_H. Clear the blink counter, blink and the timeout counter.
  - key_inc and key_dec are ignored in IDLE.
- **EDIT_x**, key_inc: selected field +1 with wrap. Hours 23→0; minutes and seconds 59→0.
- **EDIT_x**, key_dec: selected field −1 with wrap. Hours 0→23; minutes and seconds 0→59.
- key_inc and key_dec in the same cycle: no change. The keypress still resets the timeout.
- key_mode in the same cycle as key_inc or key_dec: mode wins and the field is not changed.
- Field advance on key_mode: EDIT_H→EDIT_M→EDIT_S. From EDIT_S, key_mode goes to IDLE and asserts load.
- **Blink counter**: counts 0..BLINK_MAX while busy. At BLINK_MAX it wraps to 0, toggles blink, and increments the timeout counter.
- **Timeout counter**: cleared by any key pulse.
  - When it reaches TIMEOUT_HALF, the FSM returns to IDLE with no load; set_h/m/s hold their values.
- set_h/m/s are otherwise held. They are not cleared on return to IDLE.
- Arithmetic: 8-bit unsigned. Wrap is decided by compare-and-replace, never by modulo of a wider result.

## Timing
- Reset values: state=IDLE, set_h/m/s=0, load=0, edit_sel=0, blink=0, busy=0; all counters 0.
- Reset is asynchronous. Reset mid-edit returns to IDLE at once with no load.
- All outputs are registered.
- A key pulse sampled on edge n produces a visible state or field change after edge n (1-cycle latency).
- load is high for exactly the one cycle after the committing key_mode edge. edit_sel=0 and busy=0 in that same cycle. set_h/m/s are stable during load and after it.
- Blink is 0 on entry to edit. The first toggle comes BLINK_MAX+1 cycles after entry.
- Timeout exit comes (BLINK_MAX+1)·TIMEOUT_HALF cycles after the last key, or after edit entry if no key was pressed.
- Inputs h_dec/m_dec/s_dec are sampled only on the entry cycle. Later changes in the running counter do not affect the edit.

## Test plan
Bench uses BLINK_MAX=4 and TIMEOUT_HALF=6.
- **Reset:** hold rst_n=0, then release → all outputs 0, edit_sel=0, no load for 50 cycles without keys.
- **Entry and wrap:** h/m/s=12/34/56, key_mode → edit_sel=1, set_h=12, set_m=34, set_s=56.
  - 12× key_inc → set_h=0.
  - Then 1× key_dec → set_h=23.
- **Full commit:** from the previous step, key_mode (edit_sel=2), 26× key_inc → set_m=0. Then key_mode, key_dec → set_s=55. Then key_mode → one-cycle load with set=23/0/55, and busy=0 in that cycle.
- **Timeout:** key_mode, then no keys → blink toggles every 5 cycles. edit_sel=0 after 30 cycles, load never asserted. A key_inc at cycle 20 extends the exit to 30 cycles after that key.
- **Conflicts:** in EDIT_M, key_inc+key_dec together → set_m unchanged. key_mode+key_inc together → edit_sel=3 and set_m unchanged.
- **Reset mid-edit and clamp:** enter with h_dec=30 → set_h=0. Pull rst_n low during EDIT_S → IDLE and set outputs 0 immediately, load never seen.
